// File: rtl/clock_time_keeper.sv
// Time-of-day keeper: 1 Hz prescaler driving a sec/min/hr counter with 12/24-hour display mapping.
// Optional alarm comparator is compiled in when CLOCK_ALARM_EN is defined.
module clock_time_keeper #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int FIELD_W    = 8,
    parameter int CNT_W      = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               SET_STROBE,
    input  logic [1:0]         ORDER,
    input  logic               MODE_12H,
`ifdef CLOCK_ALARM_EN
    input  logic               ALARM_ARM,
    input  logic [FIELD_W-1:0] ALARM_HR,
    input  logic [FIELD_W-1:0] ALARM_MIN,
    output logic               alarm_pulse,
`endif
    output logic [FIELD_W-1:0] seconds,
    output logic [FIELD_W-1:0] minutes,
    output logic [FIELD_W-1:0] hours,
    output logic               pm,
    output logic               sec_pulse,
    output logic               day_pulse
);

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(CLOCK_FREQ - 1);

    function automatic logic [5:0] wrap60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] wrap24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [4:0] to_12h(input logic [4:0] h);
        if (h == 5'd0)
            return 5'd12;
        else if (h > 5'd12)
            return h - 5'd12;
        else
            return h;
    endfunction

    logic [CNT_W-1:0] presc_p0;
    logic [5:0]       sec_p0;
    logic [5:0]       min_p0;
    logic [4:0]       hr_p0;
    logic             sec_pulse_p0;
    logic             day_pulse_p0;

    logic             tick;
    logic             set_req;
    logic             sec_roll;
    logic             min_roll;
    logic             day_wrap;
    logic [5:0]       sec_tick;
    logic [5:0]       min_tick;
    logic [4:0]       hr_tick;

    // Stage 0: next-second values with the full carry chain resolved in one step
    always_comb begin
        tick     = EN && (presc_p0 == PRESC_MAX);
        set_req  = SET_STROBE && (ORDER != 2'b11);
        sec_roll = (sec_p0 == 6'd59);
        min_roll = (min_p0 == 6'd59);
        day_wrap = sec_roll && min_roll && (hr_p0 == 5'd23);
        sec_tick = wrap60(sec_p0);
        min_tick = sec_roll ? wrap60(min_p0) : min_p0;
        hr_tick  = (sec_roll && min_roll) ? wrap24(hr_p0) : hr_p0;
    end

`ifdef CLOCK_ALARM_EN
    logic alarm_hit;
    logic alarm_pulse_p0;

    assign alarm_hit = ALARM_ARM
                       && (FIELD_W'(hr_tick) == ALARM_HR)
                       && (FIELD_W'(min_tick) == ALARM_MIN)
                       && (sec_tick == 6'd0);
`endif

    // Stage 0 -> p0: time registers; a set on a tick edge swallows the tick
    always_ff @(posedge CLK) begin
        if (!RST) begin
            presc_p0     <= '0;
            sec_p0       <= '0;
            min_p0       <= '0;
            hr_p0        <= '0;
            sec_pulse_p0 <= 1'b0;
            day_pulse_p0 <= 1'b0;
        end else if (set_req) begin
            presc_p0     <= '0;
            sec_pulse_p0 <= 1'b0;
            day_pulse_p0 <= 1'b0;
            case (ORDER)
                2'b00:   sec_p0 <= wrap60(sec_p0);
                2'b01:   min_p0 <= wrap60(min_p0);
                2'b10:   hr_p0  <= wrap24(hr_p0);
                default: ;
            endcase
        end else if (tick) begin
            presc_p0     <= '0;
            sec_p0       <= sec_tick;
            min_p0       <= min_tick;
            hr_p0        <= hr_tick;
            sec_pulse_p0 <= 1'b1;
            day_pulse_p0 <= day_wrap;
        end else begin
            if (EN)
                presc_p0 <= presc_p0 + 1'b1;
            sec_pulse_p0 <= 1'b0;
            day_pulse_p0 <= 1'b0;
        end
    end

`ifdef CLOCK_ALARM_EN
    always_ff @(posedge CLK) begin
        if (!RST)
            alarm_pulse_p0 <= 1'b0;
        else
            alarm_pulse_p0 <= !set_req && tick && alarm_hit;
    end

    assign alarm_pulse = alarm_pulse_p0;
`endif

    // Display mapping: combinational, never touches stored state
    assign seconds   = FIELD_W'(sec_p0);
    assign minutes   = FIELD_W'(min_p0);
    assign hours     = FIELD_W'(MODE_12H ? to_12h(hr_p0) : hr_p0);
    assign pm        = MODE_12H && (hr_p0 >= 5'd12);
    assign sec_pulse = sec_pulse_p0;
    assign day_pulse = day_pulse_p0;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Scoreboard bench for clock_time_keeper with CLOCK_FREQ=4; alarm checks when CLOCK_ALARM_EN is defined.
module tb_clock_time_keeper;

    localparam int FW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          EN;
    logic          SET_STROBE;
    logic [1:0]    ORDER;
    logic          MODE_12H;
    logic [FW-1:0] seconds;
    logic [FW-1:0] minutes;
    logic [FW-1:0] hours;
    logic          pm;
    logic          sec_pulse;
    logic          day_pulse;
`ifdef CLOCK_ALARM_EN
    logic          ALARM_ARM;
    logic [FW-1:0] ALARM_HR;
    logic [FW-1:0] ALARM_MIN;
    logic          alarm_pulse;
`endif

    clock_time_keeper #(
        .CLOCK_FREQ(4),
        .FIELD_W   (FW),
        .CNT_W     (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .SET_STROBE (SET_STROBE),
        .ORDER      (ORDER),
        .MODE_12H   (MODE_12H),
`ifdef CLOCK_ALARM_EN
        .ALARM_ARM  (ALARM_ARM),
        .ALARM_HR   (ALARM_HR),
        .ALARM_MIN  (ALARM_MIN),
        .alarm_pulse(alarm_pulse),
`endif
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .pm         (pm),
        .sec_pulse  (sec_pulse),
        .day_pulse  (day_pulse)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string         name;
        logic [FW-1:0] s;
        logic [FW-1:0] m;
        logic [FW-1:0] h;
        logic          p;
        logic          sp;
        logic          dp;
        logic          al;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge
    always @(negedge CLK) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [3*FW+2:0] act;
            logic [3*FW+2:0] req;
            e   = q.pop_front();
            act = {seconds, minutes, hours, pm, sec_pulse, day_pulse};
            req = {e.s, e.m, e.h, e.p, e.sp, e.dp};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL %s: got s=%0d m=%0d h=%0d pm=%0b sp=%0b dp=%0b, want s=%0d m=%0d h=%0d pm=%0b sp=%0b dp=%0b",
                         e.name, seconds, minutes, hours, pm, sec_pulse, day_pulse,
                         e.s, e.m, e.h, e.p, e.sp, e.dp);
            end
`ifdef CLOCK_ALARM_EN
            checks++;
            if (alarm_pulse !== e.al) begin
                errors++;
                $display("FAIL %s_alarm: got alarm_pulse=%0b, want %0b", e.name, alarm_pulse, e.al);
            end
`endif
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string n, input int s, input int m, input int h,
                       input bit p, input bit sp, input bit dp, input bit al = 1'b0);
        exp_t e;
        e.name = n;
        e.s    = FW'(s);
        e.m    = FW'(m);
        e.h    = FW'(h);
        e.p    = p;
        e.sp   = sp;
        e.dp   = dp;
        e.al   = al;
        q.push_back(e);
    endtask

    task automatic set_n(input logic [1:0] ord, input int n);
        ORDER      = ord;
        SET_STROBE = 1'b1;
        repeat (n) cyc();
        SET_STROBE = 1'b0;
        ORDER      = 2'b11;
    endtask

    initial begin
        RST        = 1'b0;
        EN         = 1'b0;
        SET_STROBE = 1'b0;
        ORDER      = 2'b11;
        MODE_12H   = 1'b1;
`ifdef CLOCK_ALARM_EN
        ALARM_ARM  = 1'b1;
        ALARM_HR   = FW'(13);
        ALARM_MIN  = FW'(1);
`endif
        repeat (2) cyc();
        chk("rst_12h", 0, 0, 12, 0, 0, 0);
        cyc();
        MODE_12H = 1'b0;
        chk("rst_24h", 0, 0, 0, 0, 0, 0);

        // Free run: pulses after edges 4, 8, 12 (cycles 5, 9, 13 after release)
        RST = 1'b1;
        EN  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk($sformatf("run_%0d", i), i / 4, 0, 0, 0, (i % 4) == 0, 0);
        end
        EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("frozen", 3, 0, 0, 0, 0, 0);
        end

        // Preset 23:59:59 from 00:00:03 and roll the day
        set_n(2'b00, 56);
        set_n(2'b01, 59);
        set_n(2'b10, 23);
        chk("preset", 59, 59, 23, 0, 0, 0);
        EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pre_wrap", 59, 59, 23, 0, 0, 0);
        end
        cyc();
        EN = 1'b0;
        chk("day_wrap", 0, 0, 0, 0, 1, 1);
        cyc();
        chk("after_wrap", 0, 0, 0, 0, 0, 0);

        // Minute set wraps without carry; 25 held hour strobes wrap 0 -> 1
        set_n(2'b01, 59);
        chk("min_59", 0, 59, 0, 0, 0, 0);
        set_n(2'b01, 1);
        chk("min_nocarry", 0, 0, 0, 0, 0, 0);
        set_n(2'b10, 25);
        chk("hr_hold25", 0, 0, 1, 0, 0, 0);

        // Set on the tick edge wins and restarts the prescaler
        set_n(2'b00, 1);
        EN = 1'b1;
        repeat (3) cyc();
        SET_STROBE = 1'b1;
        ORDER      = 2'b00;
        cyc();
        SET_STROBE = 1'b0;
        ORDER      = 2'b11;
        chk("set_on_tick", 2, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("restart_%0d", k), (k == 4) ? 3 : 2, 0, 1, 0, k == 4, 0);
        end
        repeat (3) cyc();
        SET_STROBE = 1'b1;
        ORDER      = 2'b11;
        cyc();
        SET_STROBE = 1'b0;
        EN         = 1'b0;
        chk("order11_tick", 4, 0, 1, 0, 1, 0);

        // 12-hour mapping at hr24=13
        set_n(2'b10, 12);
        MODE_12H = 1'b1;
        chk("hr13_12h", 4, 0, 1, 1, 0, 0);
        cyc();
        MODE_12H = 1'b0;
        chk("hr13_24h", 4, 0, 13, 0, 0, 0);

        // Run 13:00:59 -> 13:01:00 (alarm at 13:01 armed)
        set_n(2'b00, 55);
        chk("pre_alarm", 59, 0, 13, 0, 0, 0);
        EN = 1'b1;
        repeat (3) cyc();
        cyc();
        chk("alarm_tick", 0, 1, 13, 0, 1, 0, 1'b1);
        cyc();
        EN = 1'b0;
        chk("alarm_done", 0, 1, 13, 0, 0, 0, 1'b0);

        // Reset mid-count discards everything
        RST = 1'b0;
        cyc();
        RST = 1'b1;
        chk("rst_mid", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
